// File: rtl/spatial_conv_stream_if.sv
// Stream bundle for spatial_conv_stream: pixel input and kernel-interleaved result output.
// The slave modport is the engine's view; the master modport is the producer/consumer side.
interface spatial_conv_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KIDX_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_valid_i;
  logic                  data_ready_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  data_ready_i;
  logic [KIDX_WIDTH-1:0] kernel_idx_o;
  logic                  last_o;

  modport slave (
    input  data_i, data_valid_i, data_ready_i,
    output data_ready_o, data_o, data_valid_o, kernel_idx_o, last_o
  );

  modport master (
    output data_i, data_valid_i, data_ready_i,
    input  data_ready_o, data_o, data_valid_o, kernel_idx_o, last_o
  );
endinterface

// File: rtl/spatial_conv_stream.sv
// Streaming multi-channel, multi-kernel 2-D convolution with stride, back-pressure and saturation.
// Define CONV_RELU_EN to clamp negative results to zero after saturation.
module spatial_conv_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_WIDTH  = 16,
  parameter int N_ROWS      = 28,
  parameter int N_COLS      = 28,
  parameter int N_CHANNELS  = 1,
  parameter int N_KERNELS   = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CONV_STRIDE = 1,
  localparam int N_WEIGHTS  = N_KERNELS * N_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int ADDR_WIDTH = $clog2(N_WEIGHTS + N_KERNELS),
  localparam int KIDX_WIDTH = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  spatial_conv_stream_if.slave  stream,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  overflow_o
);

  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LB_LEN    = (KERNEL_SIZE - 1) * N_COLS + KERNEL_SIZE;
  localparam int ACC_WIDTH = 2 * DATA_WIDTH;
  localparam int ROW_W     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_W     = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {FILL, MAC, OUT} state_t;

  state_t                        state_q, state_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [CH_W-1:0]               c_q, c_d;
  logic [KIDX_WIDTH-1:0]         k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          last_win_q, last_win_d;
  logic                          overflow_q, overflow_d;

  logic signed [DATA_WIDTH-1:0]  line_buf   [N_CHANNELS][LB_LEN];
  logic signed [DATA_WIDTH-1:0]  weight_mem [N_WEIGHTS];
  logic signed [DATA_WIDTH-1:0]  bias_mem   [N_KERNELS];

  logic                          accept, win_hit, wr_ok, sat_hit;
  logic signed [DATA_WIDTH-1:0]  pix, wgt, result;
  logic signed [ACC_WIDTH-1:0]   prod, mac_sum, biased;

  assign accept = (state_q == FILL) && stream.data_valid_i;
  assign wr_ok  = wr_en_i && (state_q == FILL) && (row_q == '0) && (col_q == '0) && (ch_q == '0);

  always_comb begin
    win_hit = 1'b0;
    if ((int'(ch_q) == N_CHANNELS-1) && (int'(row_q) >= KERNEL_SIZE-1) &&
        (int'(col_q) >= KERNEL_SIZE-1) &&
        (((int'(row_q) - KERNEL_SIZE + 1) % CONV_STRIDE) == 0) &&
        (((int'(col_q) - KERNEL_SIZE + 1) % CONV_STRIDE) == 0))
      win_hit = 1'b1;
  end

  // Tap (r,c) of the window sits (KS-1-r) rows and (KS-1-c) columns behind the newest pixel.
  always_comb begin
    mac_sum = '0;
    pix     = '0;
    wgt     = '0;
    prod    = '0;
    for (int tap = 0; tap < KK; tap++) begin
      pix     = line_buf[c_q][(KERNEL_SIZE-1-tap/KERNEL_SIZE)*N_COLS + (KERNEL_SIZE-1-tap%KERNEL_SIZE)];
      wgt     = weight_mem[(int'(k_q)*N_CHANNELS + int'(c_q))*KK + tap];
      prod    = ACC_WIDTH'(pix) * ACC_WIDTH'(wgt);
      mac_sum = mac_sum + (prod >>> FRAC_WIDTH);
    end
  end

  always_comb begin
    biased  = acc_q + ACC_WIDTH'(bias_mem[k_q]);
    result  = biased[DATA_WIDTH-1:0];
    sat_hit = 1'b0;
`ifdef CONV_RELU_EN
    if (biased < 0) begin
      result = '0;
    end else if (biased > SAT_MAX) begin
      result  = SAT_MAX[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end
`else
    if (biased > SAT_MAX) begin
      result  = SAT_MAX[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (biased < SAT_MIN) begin
      result  = SAT_MIN[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    ch_d       = ch_q;
    c_d        = c_q;
    k_d        = k_q;
    acc_d      = acc_q;
    last_win_d = last_win_q;
    overflow_d = overflow_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (int'(ch_q) == N_CHANNELS-1) begin
            ch_d = '0;
            if (int'(col_q) == N_COLS-1) begin
              col_d = '0;
              row_d = (int'(row_q) == N_ROWS-1) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
          if (win_hit) begin
            state_d    = MAC;
            k_d        = '0;
            c_d        = '0;
            acc_d      = '0;
            last_win_d = (int'(row_q) == N_ROWS-1) && (int'(col_q) == N_COLS-1);
          end
        end
      end
      MAC: begin
        acc_d = acc_q + mac_sum;
        if (int'(c_q) == N_CHANNELS-1) state_d = OUT;
        else                           c_d     = c_q + 1'b1;
      end
      OUT: begin
        if (sat_hit) overflow_d = 1'b1;
        if (stream.data_ready_i) begin
          if (int'(k_q) < N_KERNELS-1) begin
            k_d     = k_q + 1'b1;
            c_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            k_d     = '0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= FILL;
      row_q      <= '0;
      col_q      <= '0;
      ch_q       <= '0;
      c_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      last_win_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ch_q       <= ch_d;
      c_q        <= c_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      last_win_q <= last_win_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset so they map onto plain registers/RAM.
  always_ff @(posedge clock_i) begin
    if (accept) begin
      for (int i = LB_LEN-1; i > 0; i--) line_buf[ch_q][i] <= line_buf[ch_q][i-1];
      line_buf[ch_q][0] <= stream.data_i;
    end
    if (wr_ok) begin
      if (int'(wr_addr_i) < N_WEIGHTS)
        weight_mem[wr_addr_i] <= wr_data_i;
      else if (int'(wr_addr_i) < N_WEIGHTS + N_KERNELS)
        bias_mem[int'(wr_addr_i) - N_WEIGHTS] <= wr_data_i;
    end
  end

  assign stream.data_ready_o = (state_q == FILL);
  assign stream.data_valid_o = (state_q == OUT);
  assign stream.data_o       = (state_q == OUT) ? result : '0;
  assign stream.kernel_idx_o = k_q;
  assign stream.last_o       = (state_q == OUT) && last_win_q && (int'(k_q) == N_KERNELS-1);
  assign overflow_o          = overflow_q;

endmodule
